// File: rtl/branch_target_buffer.sv
// Direct-mapped, tagged branch target buffer with 2-bit saturating counters.
// Optional statistics counters are enabled by defining BTB_STATS_EN.
module branch_target_buffer #(
  parameter int unsigned WordSize = 32,
  parameter int unsigned Entries  = 16
) (
  input  logic                clk,
  input  logic                rstn_h,
  input  logic [WordSize-1:0] fetch_pc,
  input  logic                stall,
  input  logic                upd_valid,
  input  logic [WordSize-1:0] upd_pc,
  input  logic [WordSize-1:0] upd_target,
  input  logic                upd_taken,
  output logic                pred_taken,
  output logic [WordSize-1:0] pred_pc,
  output logic [WordSize-1:0] pred_addr
`ifdef BTB_STATS_EN
  ,
  output logic [31:0]         lookup_cnt,
  output logic [31:0]         hit_cnt,
  output logic [31:0]         mispred_cnt
`endif
);

  localparam int unsigned IndexBits = $clog2(Entries);
  localparam int unsigned TagBits   = WordSize - IndexBits - 2;

  typedef struct packed {
    logic                valid;
    logic [TagBits-1:0]  tag;
    logic [WordSize-1:0] target;
    logic [1:0]          ctr;
  } entry_t;

  entry_t btb_q [Entries];

  logic [IndexBits-1:0] fetch_idx;
  logic [TagBits-1:0]   fetch_tag;
  logic [IndexBits-1:0] upd_idx;
  logic [TagBits-1:0]   upd_tag;

  assign fetch_idx = fetch_pc[IndexBits+1:2];
  assign fetch_tag = fetch_pc[WordSize-1:IndexBits+2];
  assign upd_idx   = upd_pc[IndexBits+1:2];
  assign upd_tag   = upd_pc[WordSize-1:IndexBits+2];

  entry_t              fetch_ent;
  logic                fetch_hit;
  logic                fetch_taken;
  logic [WordSize-1:0] fetch_addr;

  // Lookup reads the table state before this edge's update (read-before-write).
  always_comb begin
    fetch_ent   = btb_q[fetch_idx];
    fetch_hit   = fetch_ent.valid && (fetch_ent.tag == fetch_tag);
    fetch_taken = fetch_hit && fetch_ent.ctr[1];
    fetch_addr  = fetch_pc + WordSize'(4);
    if (fetch_taken) begin
      fetch_addr = fetch_ent.target;
    end
  end

  entry_t upd_ent;
  entry_t upd_ent_nxt;
  logic   upd_hit;
  logic   upd_write;

  // Counter training on hit; allocation only on a taken miss.
  always_comb begin
    upd_ent     = btb_q[upd_idx];
    upd_hit     = upd_ent.valid && (upd_ent.tag == upd_tag);
    upd_ent_nxt = upd_ent;
    upd_write   = 1'b0;
    if (upd_valid) begin
      if (upd_hit) begin
        upd_write = 1'b1;
        if (upd_taken) begin
          upd_ent_nxt.target = upd_target;
          if (upd_ent.ctr != 2'b11) begin
            upd_ent_nxt.ctr = upd_ent.ctr + 2'd1;
          end
        end else if (upd_ent.ctr != 2'b00) begin
          upd_ent_nxt.ctr = upd_ent.ctr - 2'd1;
        end
      end else if (upd_taken) begin
        upd_write          = 1'b1;
        upd_ent_nxt.valid  = 1'b1;
        upd_ent_nxt.tag    = upd_tag;
        upd_ent_nxt.target = upd_target;
        upd_ent_nxt.ctr    = 2'b10;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstn_h) begin
      for (int i = 0; i < int'(Entries); i++) begin
        btb_q[i].valid <= 1'b0;
        btb_q[i].ctr   <= 2'b01;
      end
      pred_taken <= 1'b0;
      pred_pc    <= '0;
      pred_addr  <= '0;
    end else begin
      if (upd_write) begin
        btb_q[upd_idx] <= upd_ent_nxt;
      end
      if (!stall) begin
        pred_taken <= fetch_taken;
        pred_pc    <= fetch_pc;
        pred_addr  <= fetch_addr;
      end
    end
  end

`ifdef BTB_STATS_EN
  logic upd_mispred;

  assign upd_mispred = upd_valid && ((upd_hit && upd_ent.ctr[1]) != upd_taken);

  // Free-running event counters; wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rstn_h) begin
      lookup_cnt  <= '0;
      hit_cnt     <= '0;
      mispred_cnt <= '0;
    end else begin
      if (!stall) begin
        lookup_cnt <= lookup_cnt + 32'd1;
        if (fetch_hit) begin
          hit_cnt <= hit_cnt + 32'd1;
        end
      end
      if (upd_mispred) begin
        mispred_cnt <= mispred_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
